// File: rtl/pwr_pkg.sv
// pwr_pkg: shared definitions for the UART low-power sequencing slice.
//   - one-hot state encodings and their bit positions (RUN, DRAIN, SLEEP, WAKE)
//   - wake-source encoding reported by the optional stats block
//   - default timing parameters for sleep_controller
package pwr_pkg;

    localparam int GUARD_CYCLES_DEF   = 4;
    localparam int WAKE_CYCLES_DEF    = 8;
    localparam int MIN_RUN_CYCLES_DEF = 16;

    // Bit positions inside the one-hot state vector
    localparam int S_RUN   = 0;
    localparam int S_DRAIN = 1;
    localparam int S_SLEEP = 2;
    localparam int S_WAKE  = 3;

    localparam logic [3:0] ST_RUN   = 4'b0001;
    localparam logic [3:0] ST_DRAIN = 4'b0010;
    localparam logic [3:0] ST_SLEEP = 4'b0100;
    localparam logic [3:0] ST_WAKE  = 4'b1000;

    localparam logic WAKE_SRC_HOST = 1'b0;
    localparam logic WAKE_SRC_RX   = 1'b1;

endpackage

// File: rtl/rx_wake_detect.sv
// rx_wake_detect: synchronises the raw RX line and flags a start-bit
// falling edge.
//   i_Clock     : system clock
//   i_reset     : asynchronous active-low reset (flops go to idle-high)
//   i_Rx_Serial : raw asynchronous RX line, idle high
//   rx_fall     : high for one cycle when the synchronised line goes 1->0
module rx_wake_detect (
    input  logic i_Clock,
    input  logic i_reset,
    input  logic i_Rx_Serial,
    output logic rx_fall
);

    // rx_pipe[0]/[1] form the 2-flop synchroniser, rx_pipe[2] holds the
    // previous synchronised sample.
    logic [2:0] rx_pipe;
    // vld_pipe tracks which rx_pipe stages hold samples taken after reset,
    // so a line already low at reset release is not mistaken for an edge
    // against the idle-high reset value.
    logic [2:0] vld_pipe;

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_pipe  <= 3'b111;
            vld_pipe <= 3'b000;
        end else begin
            rx_pipe  <= {rx_pipe[1:0], i_Rx_Serial};
            vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
    end

    assign rx_fall = vld_pipe[2] & rx_pipe[2] & ~rx_pipe[1];

endmodule

// File: rtl/sleep_controller.sv
// sleep_controller: sequences the UART core RUN -> DRAIN -> SLEEP -> WAKE -> RUN,
// gating its clock enable and blocking host TX while draining or asleep.
//   i_Clock      : system clock
//   i_reset      : asynchronous active-low reset
//   enter_sleep  : idle flag from the idle detector (level)
//   TX_Active    : UART TX busy (level)
//   i_Wake_Req   : host wake / TX-intent request (level)
//   i_Rx_Serial  : raw asynchronous RX line, idle high
//   o_Clk_En     : clock enable to the UART core (low only in SLEEP)
//   o_Tx_Ready   : host may issue a TX (RUN only)
//   o_Sleeping   : core is in SLEEP
//   o_Wake_Event : one-cycle pulse in the first WAKE cycle
// Optional build macro SLEEP_STATS_EN adds:
//   o_Sleep_Count   : saturating count of DRAIN->SLEEP transitions
//   o_Last_Wake_Src : source of the latest wake (0=host, 1=RX; host wins ties)
module sleep_controller
    import pwr_pkg::*;
#(
    parameter int GUARD_CYCLES   = GUARD_CYCLES_DEF,
    parameter int WAKE_CYCLES    = WAKE_CYCLES_DEF,
    parameter int MIN_RUN_CYCLES = MIN_RUN_CYCLES_DEF
) (
    input  logic        i_Clock,
    input  logic        i_reset,
    input  logic        enter_sleep,
    input  logic        TX_Active,
    input  logic        i_Wake_Req,
    input  logic        i_Rx_Serial,
    output logic        o_Clk_En,
    output logic        o_Tx_Ready,
    output logic        o_Sleeping,
`ifdef SLEEP_STATS_EN
    output logic [15:0] o_Sleep_Count,
    output logic        o_Last_Wake_Src,
`endif
    output logic        o_Wake_Event
);

    localparam int RW = $clog2(MIN_RUN_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);

    logic [3:0]    state, state_nxt;
    logic [RW-1:0] run_cnt;
    logic [GW-1:0] guard_cnt;
    logic [WW-1:0] wake_cnt;
    logic          wake_ev;
    logic          rx_fall;
    logic          armed;
    logic          drain_abort;

    rx_wake_detect u_rx_wake (
        .i_Clock     (i_Clock),
        .i_reset     (i_reset),
        .i_Rx_Serial (i_Rx_Serial),
        .rx_fall     (rx_fall)
    );

    // Holding off sleep after a wake matters because enter_sleep is still
    // high after an RX-only wake; without it we would drop straight back.
    assign armed       = (run_cnt >= RW'(MIN_RUN_CYCLES));
    assign drain_abort = TX_Active | i_Wake_Req | rx_fall | ~enter_sleep;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:
                if (armed & enter_sleep & ~TX_Active & ~i_Wake_Req & ~rx_fall)
                    state_nxt = ST_DRAIN;
            ST_DRAIN:
                if (drain_abort)
                    state_nxt = ST_RUN;
                else if (guard_cnt == GW'(GUARD_CYCLES - 1))
                    state_nxt = ST_SLEEP;
            ST_SLEEP:
                if (i_Wake_Req | rx_fall)
                    state_nxt = ST_WAKE;
            ST_WAKE:
                if (wake_cnt == WW'(WAKE_CYCLES - 1))
                    state_nxt = ST_RUN;
            default:
                state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            state     <= ST_RUN;
            run_cnt   <= '0;
            guard_cnt <= '0;
            wake_cnt  <= '0;
            wake_ev   <= 1'b0;
        end else begin
            state <= state_nxt;

            // Cleared on any entry into RUN, saturating while we stay there
            if (state[S_RUN] && state_nxt[S_RUN]) begin
                if (!armed)
                    run_cnt <= run_cnt + RW'(1);
            end else begin
                run_cnt <= '0;
            end

            guard_cnt <= (state[S_DRAIN] && state_nxt[S_DRAIN]) ? guard_cnt + GW'(1) : '0;
            wake_cnt  <= (state[S_WAKE]  && state_nxt[S_WAKE])  ? wake_cnt  + WW'(1) : '0;
            wake_ev   <= state[S_SLEEP] & state_nxt[S_WAKE];
        end
    end

`ifdef SLEEP_STATS_EN
    always_ff @(posedge i_Clock or negedge i_reset) begin
        if (!i_reset) begin
            o_Sleep_Count   <= '0;
            o_Last_Wake_Src <= WAKE_SRC_HOST;
        end else begin
            if (state[S_DRAIN] && state_nxt[S_SLEEP] && o_Sleep_Count != 16'hFFFF)
                o_Sleep_Count <= o_Sleep_Count + 16'd1;
            if (state[S_SLEEP] && state_nxt[S_WAKE])
                o_Last_Wake_Src <= i_Wake_Req ? WAKE_SRC_HOST : WAKE_SRC_RX;
        end
    end
`endif

    assign o_Clk_En     = ~state[S_SLEEP];
    assign o_Tx_Ready   = state[S_RUN];
    assign o_Sleeping   = state[S_SLEEP];
    assign o_Wake_Event = wake_ev;

endmodule
